// File: rtl/reg_pipe_elastic.sv
// Elastic register pipeline: DEPTH stages of WIDTH bits with valid/ready on both ends and bubble collapsing.
// Optional occupancy counter port `count` is built only when REG_PIPE_COUNT_EN is defined.
module reg_pipe_elastic #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef REG_PIPE_COUNT_EN
  ,
  output logic [CW-1:0]    count
`endif
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, while in_ready depends combinationally on out_ready.
  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] en;
  logic [DEPTH-1:0] up_v;
  logic [WIDTH-1:0] up_d [DEPTH];

  // A stage may advance if any stage at or downstream of it is empty, or the consumer takes the head.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      en[i] = out_ready;
      for (int j = i; j < DEPTH; j++) begin
        en[i] = en[i] | ~v[j];
      end
    end
  end

  always_comb begin
    up_v[0] = in_valid;
    up_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      up_v[i] = v[i-1];
      up_d[i] = d[i-1];
    end
  end

  assign in_ready  = en[0] & ~clr;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else if (clr) begin
      // Flush drops validity only; data registers keep their stale contents.
      v <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (en[i]) begin
          v[i] <= up_v[i];
          if (up_v[i]) d[i] <= up_d[i];
        end
      end
    end
  end

`ifdef REG_PIPE_COUNT_EN
  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Occupancy only changes through transfers, so track it incrementally alongside v.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      count <= count + CW'(in_xfer) - CW'(out_xfer);
    end
  end
`endif

endmodule

// File: tb/tb_reg_pipe_elastic.sv
// Directed testbench for reg_pipe_elastic (WIDTH=4, DEPTH=3); count checks compile in with REG_PIPE_COUNT_EN.
module tb_reg_pipe_elastic;

  localparam int WIDTH = 4;
  localparam int DEPTH = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             clr;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
`ifdef REG_PIPE_COUNT_EN
  logic [CW-1:0]    count;
`endif

  int vectors;
  int miscompares;

  reg_pipe_elastic #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef REG_PIPE_COUNT_EN
    ,
    .count     (count)
`endif
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic exp_v, input logic [WIDTH-1:0] exp_d);
    check({tag, "_valid"}, 8'(out_valid), 8'(exp_v));
    if (exp_v) check({tag, "_data"}, 8'(out_data), 8'(exp_d));
  endtask

  task automatic check_count(input string tag, input int exp);
`ifdef REG_PIPE_COUNT_EN
    check(tag, 8'(count), 8'(exp));
`endif
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst       = 1'b1;
    clr       = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'hF;
    out_ready = 1'b0;

    // Reset held with input offered
    tick();
    tick();
    check("rst_out_valid", 8'(out_valid), 8'h0);
    check("rst_out_data", 8'(out_data), 8'h0);
    check_count("rst_count", 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_in_ready", 8'(in_ready), 8'h1);

    // Streaming with out_ready high: latency DEPTH edges from presentation
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 4'h1;
    tick();
    in_data = 4'hA;
    tick();
    check("stream_lat_early", 8'(out_valid), 8'h0);
    in_data = 4'hF;
    tick();
    check_out("stream_1", 1'b1, 4'h1);
    in_data = 4'h5;
    tick();
    check_out("stream_A", 1'b1, 4'hA);
    in_valid = 1'b0;
    tick();
    check_out("stream_F", 1'b1, 4'hF);
    tick();
    check_out("stream_5", 1'b1, 4'h5);
    tick();
    check_out("stream_empty", 1'b0, 4'h0);
    check_count("stream_count", 0);

    // Back-pressure: fill with 1,2,3 while stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'h1;
    tick();
    in_data = 4'h2;
    tick();
    in_data = 4'h3;
    tick();
    in_data = 4'h4;
    #1;
    check("full_in_ready", 8'(in_ready), 8'h0);
    check_out("full_head", 1'b1, 4'h1);
    check_count("full_count", 3);
    tick();
    check_out("frozen_head", 1'b1, 4'h1);
    check_count("frozen_count", 3);

    // Full pipeline with simultaneous in/out transfer
    out_ready = 1'b1;
    in_data   = 4'h9;
    #1;
    check("simul_in_ready", 8'(in_ready), 8'h1);
    tick();
    check_out("simul_2", 1'b1, 4'h2);
    check_count("simul_count", 3);
    in_valid = 1'b0;
    tick();
    check_out("drain_3", 1'b1, 4'h3);
    check_count("drain_count2", 2);
    tick();
    check_out("drain_9", 1'b1, 4'h9);
    tick();
    check_out("drain_empty", 1'b0, 4'h0);
    check_count("drain_count0", 0);

    // Flush: 5,6 in flight, clr with 7 offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'h5;
    tick();
    in_data = 4'h6;
    tick();
    check_count("pre_flush_count", 2);
    clr     = 1'b1;
    in_data = 4'h7;
    #1;
    check("flush_in_ready", 8'(in_ready), 8'h0);
    tick();
    clr       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_out("flush_out", 1'b0, 4'h0);
    check_count("flush_count", 0);
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      check_out("flush_nothing", 1'b0, 4'h0);
    end
    in_valid = 1'b1;
    in_data  = 4'h9;
    tick();
    in_valid = 1'b0;
    tick();
    check_out("post_flush_early", 1'b0, 4'h0);
    tick();
    check_out("post_flush_9", 1'b1, 4'h9);
    tick();
    check_out("post_flush_empty", 1'b0, 4'h0);

    // Async reset mid-stream with two items in flight
    in_valid = 1'b1;
    in_data  = 4'hC;
    tick();
    in_data = 4'hD;
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check_out("pre_rst_head", 1'b1, 4'hC);
    check_count("pre_rst_count", 2);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 8'(out_valid), 8'h0);
    check("async_rst_out_data", 8'(out_data), 8'h0);
    check_count("async_rst_count", 0);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < DEPTH + 1; k++) begin
      tick();
      check_out("post_rst_nothing", 1'b0, 4'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
